router_fsm: RTL
===============

// Module: router_fsm
// PURPOSE
//  Packet-sequencing controller for the 1x3 router. It decodes the header address,
//  sequences header/payload/parity loading and stalls on full output FIFOs.
//  It drives the register block (lfd/ld/laf/full/rst_int) and the sync block
//  (detect_add, write_enb_reg). Its busy output back-pressures the packet source.
// PARAMETERS
//  ADDR_W       2      header address width; only 2 is supported (ports 0..2, 3 = invalid)
// PORTS
//  clock        in   1       system clock, all state updates on rising edge
//  resetn       in   1       synchronous active-low reset
//  pkt_valid    in   1       source is presenting packet bytes (high header..last payload)
//  data_in      in   ADDR_W  header address field (data_in[1:0] of the source byte)
//  fifo_full    in   1       full flag of the FIFO selected by the sync block
//  fifo_empty_0 in   1       empty flag, FIFO 0 (same for _1, _2)
//  fifo_empty_1 in   1       empty flag, FIFO 1
//  fifo_empty_2 in   1       empty flag, FIFO 2
//  soft_reset_0 in   1       timeout soft reset, FIFO 0 (same for _1, _2)
//  soft_reset_1 in   1       timeout soft reset, FIFO 1
//  soft_reset_2 in   1       timeout soft reset, FIFO 2
//  parity_done  in   1       register block has captured the parity byte
//  low_pkt_valid in  1       pkt_valid fell while the FSM was stalled in FIFO_FULL
//  detect_add   out  1       state==DECODE_ADDRESS; sync block latches address
//  lfd_state    out  1       state==LOAD_FIRST_DATA (header write)
//  ld_state     out  1       state==LOAD_DATA
//  laf_state    out  1       state==LOAD_AFTER_FULL
//  full_state   out  1       state==FIFO_FULL_STATE
//  write_enb_reg out 1       LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
//  rst_int_reg  out  1       state==CHECK_PARITY_ERROR; clears internal parity/flags
//  busy         out  1       high in every state except DECODE_ADDRESS and LOAD_DATA
// BEHAVIOUR
//  - Moore FSM. State is registered; all outputs are decoded combinationally from the
//    state only, so there are 0 cycles from state to outputs.
//  - Reset (resetn=0 at edge): state=DECODE_ADDRESS, addr_q=0. After reset
//    detect_add=1 and every other output is 0.
//  - addr_q: loaded from data_in when state==DECODE_ADDRESS && pkt_valid; held otherwise.
//  - Transitions (first match wins):
//    DECODE_ADDRESS: pkt_valid&&data_in<3&&empty[data_in] -> LOAD_FIRST_DATA;
//      pkt_valid&&data_in<3&&!empty[data_in] -> WAIT_TILL_EMPTY;
//      data_in==3 or !pkt_valid -> stay (an invalid packet is dropped; busy stays 0).
//    LOAD_FIRST_DATA -> LOAD_DATA (unconditional, 1 cycle).
//    LOAD_DATA: fifo_full -> FIFO_FULL_STATE; !pkt_valid -> LOAD_PARITY; else stay.
//    FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
//    LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; low_pkt_valid -> LOAD_PARITY;
//      else -> LOAD_DATA.
//    LOAD_PARITY -> CHECK_PARITY_ERROR (unconditional).
//    CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
//    WAIT_TILL_EMPTY: empty[addr_q] -> LOAD_FIRST_DATA; else stay.
//  - Soft reset: soft_reset_[addr_q]=1 in any state other than DECODE_ADDRESS forces
//    next state DECODE_ADDRESS. This overrides all other transitions; only resetn
//    has higher priority. Soft resets of non-selected ports are ignored.
//  - Simultaneous fifo_full and !pkt_valid in LOAD_DATA: fifo_full wins.
//  - resetn asserted mid-packet: the FSM returns to DECODE_ADDRESS on the next edge.
//    Partial-packet cleanup is the responsibility of the FIFOs and register block.
//  - Unused encodings -> DECODE_ADDRESS next cycle; outputs are decoded as DECODE_ADDRESS.
// TESTING
//  1 reset: resetn=0 for 2 cycles -> detect_add=1, busy=0, all others 0.
//  2 addr=1, empty_1=1, 4 payload bytes then pkt_valid=0 -> states DA,LFD,LD x4,LP,CPE,DA;
//    busy=1 only in LFD/LP/CPE.
//  3 fifo_full=1 during LD for 3 cycles -> FFS x3 with full_state=1, then LAF;
//    low_pkt_valid=1 -> LP.
//  4 addr=2, empty_2=0 for 5 cycles -> WTE x5 with busy=1; empty_2=1 -> LFD next cycle.
//  5 soft_reset_0=1 while in WTE/LD with addr_q=0 -> DA next cycle;
//    soft_reset_1=1 at the same time with addr_q=0 -> no effect.
//  6 pkt_valid=1, data_in=3 -> remains DA, busy=0, lfd_state never asserts.

Source files
------------

// File: rtl/router_fsm_if.sv
// Signal bundle between the 1x3 router sequencing FSM and the blocks around it.
// The master side is the environment (source, FIFOs, register and sync blocks).
// The slave side is the FSM itself.
interface router_fsm_if #(
    parameter int ADDR_W = 2
);
    // Inputs to the FSM
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic              fifo_empty_0;
    logic              fifo_empty_1;
    logic              fifo_empty_2;
    logic              soft_reset_0;
    logic              soft_reset_1;
    logic              soft_reset_2;
    logic              parity_done;
    logic              low_pkt_valid;

    // Outputs from the FSM
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              write_enb_reg;
    logic              rst_int_reg;
    logic              busy;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  write_enb_reg, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output write_enb_reg, rst_int_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router.
// Decodes the header address, sequences header/payload/parity loading and
// stalls while the selected output FIFO is full. Moore machine: every output
// is a pure decode of the registered state.
module router_fsm #(
    parameter int ADDR_W = 2
) (
    input  logic         clock,
    input  logic         resetn,
    router_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic inEmptySel;
    logic addrEmptySel;
    logic addrSoftSel;

    // Pick the empty/soft-reset flags of the port named by the incoming header and by the latched address
    always_comb begin
        inEmptySel   = 1'b0;
        addrEmptySel = 1'b0;
        addrSoftSel  = 1'b0;
        case (bus.data_in)
            2'd0:    inEmptySel = bus.fifo_empty_0;
            2'd1:    inEmptySel = bus.fifo_empty_1;
            2'd2:    inEmptySel = bus.fifo_empty_2;
            default: inEmptySel = 1'b0;
        endcase
        case (addr_q)
            2'd0: begin
                addrEmptySel = bus.fifo_empty_0;
                addrSoftSel  = bus.soft_reset_0;
            end
            2'd1: begin
                addrEmptySel = bus.fifo_empty_1;
                addrSoftSel  = bus.soft_reset_1;
            end
            2'd2: begin
                addrEmptySel = bus.fifo_empty_2;
                addrSoftSel  = bus.soft_reset_2;
            end
            default: begin
                addrEmptySel = 1'b0;
                addrSoftSel  = 1'b0;
            end
        endcase
    end

    // Capture the header address whenever a byte is presented during address decode
    always_comb begin
        addr_d = addr_q;
        if (state_q == DECODE_ADDRESS && bus.pkt_valid) begin
            addr_d = bus.data_in;
        end
    end

    // Next-state logic; a soft reset of the selected port overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && bus.data_in != 2'd3) begin
                    state_d = inEmptySel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!bus.pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (bus.low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (addrEmptySel) begin
                    state_d = LOAD_FIRST_DATA;
                end
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        if (state_q != DECODE_ADDRESS && addrSoftSel) begin
            state_d = DECODE_ADDRESS;
        end
    end

    // State and address registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Decode the control strobes from the current state only
    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.busy          = 1'b1;
        case (state_q)
            LOAD_FIRST_DATA: bus.lfd_state = 1'b1;
            LOAD_DATA: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b0;
            end
            FIFO_FULL_STATE: bus.full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LOAD_PARITY:        bus.write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: bus.rst_int_reg   = 1'b1;
            WAIT_TILL_EMPTY:    bus.busy          = 1'b1;
            default: begin
                bus.detect_add = 1'b1;
                bus.busy       = 1'b0;
            end
        endcase
    end

endmodule
